// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result path.
package systolic_pkg;

  localparam int L_DEF     = 8;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } drain_state_e;

  typedef logic [L_DEF-1:0][WIDTH_DEF-1:0] row_t;

  // Width of a counter/address able to index n distinct values (min 1 bit).
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int CW   = addr_w(DEPTH + 1),
  localparam int PW   = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// De-skews per-lane array results into rows, buffers them and hands them to the
// result SRAM writer with a wrapping row address.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int L      = 8,
  parameter int WIDTH  = 32,
  parameter int ENTRYS = 1024,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [addr_w(ENTRYS+1)-1:0]  cfg_rows,
  input  logic [L-1:0]                 in_valid,
  input  logic [L*WIDTH-1:0]           in_data,
  output logic                         hold,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [L*WIDTH-1:0]           out_data,
  output logic [addr_w(ENTRYS)-1:0]    out_addr,
  output logic                         out_last,
  output logic                         done,
  output logic                         err
);

  localparam int RW = addr_w(ENTRYS + 1);
  localparam int AW = addr_w(ENTRYS);
  localparam int CW = addr_w(DEPTH + 1);

  if (DEPTH < 2 * L) begin : g_depth_check
    $error("systolic_drain: DEPTH must be at least 2*L");
  end

  drain_state_e             state;
  logic [RW-1:0]            cfg_q;
  logic [RW-1:0]            pushed;
  logic [RW-1:0]            popped;
  logic [L-1:0]             al_valid;
  logic [L-1:0][WIDTH-1:0]  al_data;
  logic                     row_full;
  logic                     misalign;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            count;

  // Lane i waits L-1-i cycles so every lane of a row meets lane L-1.
  for (genvar i = 0; i < L; i++) begin : g_lane
    localparam int D = L - 1 - i;
    if (D == 0) begin : g_pass
      assign al_valid[i] = in_valid[i];
      assign al_data[i]  = in_data[i*WIDTH +: WIDTH];
    end else begin : g_pipe
      logic [D-1:0]            v_q;
      logic [D-1:0][WIDTH-1:0] d_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          d_q <= '0;
        end else begin
          v_q[0] <= in_valid[i];
          d_q[0] <= in_data[i*WIDTH +: WIDTH];
          for (int k = 1; k < D; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end
      assign al_valid[i] = v_q[D-1];
      assign al_data[i]  = d_q[D-1];
    end
  end

  assign row_full  = &al_valid;
  assign misalign  = (|al_valid) && !row_full;
  assign push      = row_full && (state == RUN) && (pushed < cfg_q) && !fifo_full;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (popped == cfg_q - RW'(1));
  assign hold      = (CW'(DEPTH) - count) < CW'(L);

  sync_fifo #(
    .WIDTH (L * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (al_data),
    .dout  (out_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cfg_q    <= '0;
      pushed   <= '0;
      popped   <= '0;
      out_addr <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push) pushed <= pushed + RW'(1);
      if (pop) begin
        popped   <= popped + RW'(1);
        out_addr <= (out_addr == AW'(ENTRYS - 1)) ? '0 : out_addr + AW'(1);
      end
      if (misalign || (row_full && !push)) err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_q    <= cfg_rows;
            pushed   <= '0;
            popped   <= '0;
            out_addr <= '0;
            err      <= 1'b0;
            if (cfg_rows == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pop && out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Randomised directed bench for systolic_drain with a row-level scoreboard.
module tb_systolic_drain;
  localparam int L = 4;
  localparam int W = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [L-1:0]   in_valid;
  logic [L*W-1:0] in_data;
  logic           out_ready;
  logic           start_a, start_b;
  logic [10:0]    cfg_a;
  logic [2:0]     cfg_b;

  logic           hold_a, ov_a, ol_a, dn_a, er_a;
  logic [L*W-1:0] od_a;
  logic [9:0]     oa_a;
  logic           hold_b, ov_b, ol_b, dn_b, er_b;
  logic [L*W-1:0] od_b;
  logic [1:0]     oa_b;

  systolic_drain #(.L(L), .WIDTH(W), .ENTRYS(1024), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start_a), .cfg_rows(cfg_a),
    .in_valid(in_valid), .in_data(in_data), .hold(hold_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .out_addr(oa_a), .out_last(ol_a), .done(dn_a), .err(er_a)
  );

  systolic_drain #(.L(L), .WIDTH(W), .ENTRYS(4), .DEPTH(D)) dut4 (
    .clk(clk), .rst(rst), .start(start_b), .cfg_rows(cfg_b),
    .in_valid(in_valid), .in_data(in_data), .hold(hold_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .out_addr(oa_b), .out_last(ol_b), .done(dn_b), .err(er_b)
  );

  bit             use_b;
  logic           s_hold, s_valid, s_last, s_done, s_err;
  logic [L*W-1:0] s_data;
  int             s_addr, s_entrys;
  assign s_hold   = use_b ? hold_b : hold_a;
  assign s_valid  = use_b ? ov_b : ov_a;
  assign s_last   = use_b ? ol_b : ol_a;
  assign s_done   = use_b ? dn_b : dn_a;
  assign s_err    = use_b ? er_b : er_a;
  assign s_data   = use_b ? od_b : od_a;
  assign s_addr   = use_b ? int'(oa_b) : int'(oa_a);
  assign s_entrys = use_b ? 4 : 1024;

  int errors = 0;
  int checks = 0;

  logic [L-1:0][W-1:0] rows [32];
  int issue_cyc [32];
  int cyc = 0;
  int n_rows, n_issued, pop_idx, pop_base, ncfg, ready_mode;
  int late_row, late_lane;
  int first_valid, last_pop_cyc, done_seen, done_cyc;
  bit gaps, chk_hold, hold_seen, stall;
  logic [L*W-1:0] sv_data;
  int sv_addr;
  logic sv_last;

  task automatic chk(input string tag, input logic [L*W-1:0] obs, input logic [L*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: issue rows onto the skewed lanes, then score the output side.
  task automatic step();
    logic [L-1:0]   v;
    logic [L*W-1:0] d;
    int dl, occ;
    if (chk_hold) begin
      occ = 0;
      for (int r = 0; r < n_issued; r++) if (issue_cyc[r] + L <= cyc) occ++;
      occ -= pop_idx;
      chk("hold", s_hold, ((D - occ) < L));
    end
    if (s_hold) hold_seen = 1;
    if (n_issued < n_rows && !s_hold && (!gaps || $urandom_range(0, 2) != 0)) begin
      issue_cyc[n_issued] = cyc;
      n_issued++;
    end
    v = '0;
    d = '0;
    for (int i = 0; i < L; i++)
      for (int r = 0; r < n_issued; r++) begin
        dl = i + ((r == late_row && i == late_lane) ? 1 : 0);
        if (issue_cyc[r] + dl == cyc) begin
          v[i] = 1'b1;
          d[i*W +: W] = rows[r][i];
        end
      end
    in_valid = v;
    in_data  = d;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (n_issued == n_rows) && (cyc > issue_cyc[n_rows-1] + L + 1);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (stall) begin
      chk("stall_valid", s_valid, 1);
      chk("stall_data", s_data, sv_data);
      chk("stall_addr", s_addr, sv_addr);
      chk("stall_last", s_last, sv_last);
    end
    stall = 0;
    if (s_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (out_ready) begin
        chk("pop_in_range", (pop_idx < ncfg), 1);
        chk("pop_data", s_data, rows[pop_idx + pop_base]);
        chk("pop_addr", s_addr, pop_idx % s_entrys);
        chk("pop_last", s_last, (pop_idx == ncfg - 1));
        pop_idx++;
        last_pop_cyc = cyc;
      end else begin
        stall   = 1;
        sv_data = s_data;
        sv_addr = s_addr;
        sv_last = s_last;
      end
    end
    if (s_done) begin
      done_seen++;
      done_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic setup(input bit b, input int cfg, input int nrows, input int rmode,
                       input bit gp, input bit fixed);
    use_b = b;
    for (int r = 0; r < 32; r++)
      for (int i = 0; i < L; i++)
        rows[r][i] = fixed ? 32'(16 * (r + 1) + i) : $urandom();
    n_rows = nrows; n_issued = 0; pop_idx = 0; pop_base = 0; ncfg = cfg;
    ready_mode = rmode; gaps = gp; first_valid = -1; done_seen = 0; done_cyc = -1;
    last_pop_cyc = -1; stall = 0; chk_hold = 1; hold_seen = 0; late_row = -1; late_lane = -1;
    out_ready = 1'b0;
  endtask

  task automatic do_start(input int cfg);
    in_valid = '0;
    in_data  = '0;
    if (use_b) begin start_b = 1'b1; cfg_b = 3'(cfg); end
    else       begin start_a = 1'b1; cfg_a = 11'(cfg); end
    @(negedge clk);
    cyc++;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic finish_run(input int budget);
    int t;
    t = 0;
    while (done_seen == 0 && t < budget) begin step(); t++; end
    chk("run_timeout", (done_seen != 0), 1);
    chk("pop_count", pop_idx, ncfg);
    chk("done_after_last_pop", done_cyc, last_pop_cyc + 1);
    step();
    chk("done_single_cycle", done_seen, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hold"}, s_hold, 0);
    chk({tag, "_valid"}, s_valid, 0);
    chk({tag, "_data"}, s_data, 0);
    chk({tag, "_addr"}, s_addr, 0);
    chk({tag, "_last"}, s_last, 0);
    chk({tag, "_done"}, s_done, 0);
    chk({tag, "_err"}, s_err, 0);
  endtask

  initial begin
    rst = 1'b1; start_a = 0; start_b = 0; cfg_a = 0; cfg_b = 0;
    in_valid = 0; in_data = 0; out_ready = 0; use_b = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset_idle");

    // Three fixed rows, writer always ready.
    setup(0, 3, 3, 0, 0, 1);
    do_start(3);
    finish_run(60);
    chk("first_valid_latency", first_valid - issue_cyc[0], L);
    chk("err_clean_fixed", s_err, 0);

    // Writer stalled while eight rows arrive; hold must throttle the array.
    setup(0, 8, 8, 1, 0, 0);
    do_start(8);
    finish_run(120);
    chk("hold_seen", hold_seen, 1);
    chk("err_clean_stall", s_err, 0);

    // Random gaps and random writer readiness.
    setup(0, 12, 12, 2, 1, 0);
    do_start(12);
    finish_run(300);
    chk("err_clean_random", s_err, 0);

    // Lane 2 arrives one cycle late on the first row.
    setup(0, 1, 1, 0, 0, 0);
    chk_hold  = 0;
    late_row  = 0;
    late_lane = 2;
    do_start(1);
    repeat (8) step();
    chk("misalign_err", s_err, 1);
    chk("misalign_no_output", first_valid, -1);
    n_rows   = 2;
    pop_base = 1;
    finish_run(40);
    chk("misalign_err_sticky", s_err, 1);

    // Zero-row job.
    setup(0, 0, 0, 0, 0, 0);
    do_start(0);
    chk("start_clears_err", s_err, 0);
    repeat (4) step();
    chk("zero_rows_done", done_seen, 1);
    chk("zero_rows_no_valid", first_valid, -1);

    // Four-entry SRAM: addresses wrap.
    setup(1, 6, 6, 0, 0, 0);
    do_start(6);
    finish_run(80);
    chk("err_clean_wrap", s_err, 0);

    // Reset in the middle of row 4.
    setup(1, 6, 6, 0, 0, 0);
    do_start(6);
    for (int t = 0; t < 60 && pop_idx < 4; t++) step();
    chk("reached_row4", pop_idx, 4);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    in_valid = '0;
    @(negedge clk);
    chk_reset_outputs("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
